// File: rtl/assoc_cache_ram.sv
// assoc_cache_ram
//   Set-associative, write-through, no-write-allocate data cache with its own
//   backing RAM. The backing RAM models slow main memory: every access to it
//   costs MISS_LAT cycles, and a read miss then copies the whole line into
//   the cache one word per cycle.
//
//   The backing RAM has no power-up image and is not reset. Its contents are
//   undefined until they are written through the write port.
//
//   Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters.
//
// Ports
//   clk        clock, every state update happens on posedge
//   rst        synchronous active-high reset
//   ce         request valid
//   we         1 = write, 0 = read
//   addr       byte address; word index = addr[MEM_DEPTH_LOG+1:2]
//   sel        byte enables for writes (sel[0] -> data_i[7:0])
//   data_i     write data
//   data_o     read data (combinational on a hit, registered in DONE)
//   hit_o      combinational read hit in IDLE
//   ready_o    one-cycle completion pulse for a slow-path read or write
//   busy_o     high whenever the controller is outside IDLE
//   hit_cnt_o  (CACHE_STATS_EN) read hits sampled in IDLE
//   miss_cnt_o (CACHE_STATS_EN) read misses started
//
// LINE_WORDS_LOG and SETS_LOG must both be at least 1.
module assoc_cache_ram #(
  parameter int MEM_DEPTH_LOG  = 10,
  parameter int LINE_WORDS_LOG = 2,
  parameter int SETS_LOG       = 1,
  parameter int WAYS           = 2,
  parameter int MISS_LAT       = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        hit_o,
  output logic        ready_o,
  output logic        busy_o
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int LINE_WORDS = 1 << LINE_WORDS_LOG;
  localparam int SETS       = 1 << SETS_LOG;
  localparam int MEM_DEPTH  = 1 << MEM_DEPTH_LOG;
  localparam int TAG_W      = MEM_DEPTH_LOG - LINE_WORDS_LOG - SETS_LOG;
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W      = $clog2(MISS_LAT + 1);

  typedef enum logic [2:0] {IDLE, MISS_WAIT, FILL, WR_WAIT, DONE} state_t;

  state_t state_q, state_d;

  logic [31:0]         ram       [MEM_DEPTH];
  logic [31:0]         line_data [SETS][WAYS][LINE_WORDS];
  logic [TAG_W-1:0]    tag_q     [SETS][WAYS];
  logic [WAYS-1:0]     valid_q   [SETS];
  logic [WAY_W-1:0]    rr_q      [SETS];

  logic [CNT_W-1:0]          wait_cnt_q;
  logic [LINE_WORDS_LOG-1:0] fill_idx_q;
  logic [WAY_W-1:0]          victim_q;
  logic [31:0]               rd_data_q;

  logic [MEM_DEPTH_LOG-1:0]  word_idx;
  logic [LINE_WORDS_LOG-1:0] req_off;
  logic [SETS_LOG-1:0]       set_idx;
  logic [TAG_W-1:0]          req_tag;
  logic                      unused_addr_bits;

  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic [31:0]      hit_word;
  logic [31:0]      fill_word;
  logic             wait_last, fill_last, read_hit, miss_start;
  logic             fill_en, wr_commit;

  // Byte addresses alias above the RAM depth and inside a word.
  assign word_idx         = addr[MEM_DEPTH_LOG+1:2];
  assign req_off          = word_idx[LINE_WORDS_LOG-1:0];
  assign set_idx          = word_idx[LINE_WORDS_LOG +: SETS_LOG];
  assign req_tag          = word_idx[MEM_DEPTH_LOG-1 -: TAG_W];
  assign unused_addr_bits = ^{addr[31:MEM_DEPTH_LOG+2], addr[1:0]};

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // Tag lookup across the ways of the addressed set, plus victim choice:
  // the lowest-index invalid way wins, otherwise the set's round-robin way.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    victim  = rr_q[set_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) victim = WAY_W'(w);
    end
  end

  assign hit_word   = line_data[set_idx][hit_way][req_off];
  assign fill_word  = ram[{req_tag, set_idx, fill_idx_q}];
  assign wait_last  = (wait_cnt_q == CNT_W'(MISS_LAT - 1));
  assign fill_last  = &fill_idx_q;
  assign read_hit   = (state_q == IDLE) && ce && !we && hit_any;
  assign miss_start = (state_q == IDLE) && ce && !we && !hit_any;
  // Dropping ce while busy aborts, so every storage write is qualified by ce.
  assign fill_en    = !rst && (state_q == FILL) && ce;
  assign wr_commit  = !rst && (state_q == WR_WAIT) && ce && wait_last;

  // Next-state logic; ce low anywhere outside IDLE is an abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ce && we)      state_d = WR_WAIT;
        else if (miss_start) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (!ce)           state_d = IDLE;
        else if (wait_last) state_d = FILL;
      end
      FILL: begin
        if (!ce)           state_d = IDLE;
        else if (fill_last) state_d = DONE;
      end
      WR_WAIT: begin
        if (!ce)           state_d = IDLE;
        else if (wait_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Reset forces everything low, even a pending ready_o in DONE.
  always_comb begin
    data_o  = '0;
    hit_o   = 1'b0;
    ready_o = 1'b0;
    busy_o  = 1'b0;
    if (!rst) begin
      busy_o = (state_q != IDLE);
      if (read_hit) begin
        hit_o  = 1'b1;
        data_o = hit_word;
      end
      if (state_q == DONE) begin
        ready_o = 1'b1;
        if (ce) data_o = rd_data_q;
      end
    end
  end

  // Control state: FSM, wait/fill counters, valid bits, round-robin pointers.
  // The victim's valid bit drops as the miss starts, so an aborted fill
  // leaves that way invalid rather than half-filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      fill_idx_q <= '0;
      victim_q   <= '0;
      rd_data_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          fill_idx_q <= '0;
          if (miss_start) begin
            victim_q                 <= victim;
            valid_q[set_idx][victim] <= 1'b0;
          end
          if (ce && we) rd_data_q <= '0;
        end
        MISS_WAIT, WR_WAIT: begin
          wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
        FILL: begin
          if (ce) begin
            fill_idx_q <= fill_idx_q + LINE_WORDS_LOG'(1);
            if (fill_idx_q == req_off) rd_data_q <= fill_word;
            if (fill_last) begin
              valid_q[set_idx][victim_q] <= 1'b1;
              rr_q[set_idx] <= (rr_q[set_idx] == WAY_W'(WAYS - 1)) ?
                               '0 : rr_q[set_idx] + WAY_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Backing RAM: write-through commit on the final wait cycle.
  always_ff @(posedge clk) begin
    if (wr_commit) ram[word_idx] <= byte_merge(ram[word_idx], data_i, sel);
  end

  // Cache line storage: line fill, and the write-through update of a
  // resident line on the same edge as the RAM commit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_data[set_idx][victim_q][fill_idx_q] <= fill_word;
      if (fill_last) tag_q[set_idx][victim_q] <= req_tag;
    end
    if (wr_commit && hit_any) begin
      line_data[set_idx][hit_way][req_off] <= byte_merge(hit_word, data_i, sel);
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating statistics; writes and aborts do not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (read_hit && (hit_cnt_o != 32'hFFFF_FFFF))
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if (miss_start && (miss_cnt_o != 32'hFFFF_FFFF))
        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_assoc_cache_ram.sv
// tb_assoc_cache_ram
//   Directed bench for assoc_cache_ram with MISS_LAT=4, 4-word lines,
//   2 sets, 2 ways. RAM word i is loaded with 32'h1000_0000+i through the
//   write port, the cache is reset, then a vector table and a few
//   multi-cycle sequences (abort, reset during fill) run.
//   Define CACHE_STATS_EN to also exercise the statistics counters.
module tb_assoc_cache_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        hit_o, ready_o, busy_o;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  int checks = 0;
  int passes = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        exp_hit;
    int          exp_lat;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  assoc_cache_ram #(
    .MEM_DEPTH_LOG (10),
    .LINE_WORDS_LOG(2),
    .SETS_LOG      (1),
    .WAYS          (2),
    .MISS_LAT      (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .addr   (addr),
    .sel    (sel),
    .data_i (data_i),
    .data_o (data_o),
    .hit_o  (hit_o),
    .ready_o(ready_o),
    .busy_o (busy_o)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt_o (hit_cnt_o),
    .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic add_vec(input string name, input logic [31:0] a, input logic w,
                         input logic [3:0] s, input logic [31:0] d, input logic h,
                         input int lat, input logic [31:0] ed);
    vec_t v;
    v.name = name; v.addr = a; v.we = w; v.sel = s; v.wdata = d;
    v.exp_hit = h; v.exp_lat = lat; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge. Hits are checked combinationally and held for one
  // edge; slow operations count cycles after the request edge until ready_o.
  task automatic applyStimulus(input vec_t v);
    int n;
    bit got;
    ce = 1'b1; we = v.we; addr = v.addr; sel = v.sel; data_i = v.wdata;
    #1;
    checkOutput({v.name, " hit_o"}, 32'(hit_o), 32'(v.exp_hit));
    if (v.exp_hit) begin
      checkOutput({v.name, " data_o"}, data_o, v.exp_data);
      checkOutput({v.name, " busy_o"}, 32'(busy_o), 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput({v.name, " busy_o held"}, 32'(busy_o), 32'd0);
    end else begin
      n = 0;
      got = 1'b0;
      while (!got && n < 100) begin
        @(posedge clk);
        @(negedge clk);
        n++;
        if (n == 1) checkOutput({v.name, " busy_o"}, 32'(busy_o), 32'd1);
        if (ready_o) got = 1'b1;
      end
      checkOutput({v.name, " latency"}, 32'(n), 32'(v.exp_lat));
      checkOutput({v.name, " data_o at ready"}, data_o, v.exp_data);
      checkOutput({v.name, " hit_o at ready"}, 32'(hit_o), 32'd0);
      ce = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput({v.name, " busy_o after done"}, 32'(busy_o), 32'd0);
      checkOutput({v.name, " ready_o after done"}, 32'(ready_o), 32'd0);
    end
    ce = 1'b0;
    we = 1'b0;
  endtask

  initial begin
    vec_t v;
    int ready_seen;

    do_reset();

    // Load RAM word i with 32'h1000_0000 + i for the addresses used below.
    for (int i = 0; i < 48; i++) begin
      v.name = "preload"; v.addr = 32'(i * 4); v.we = 1'b1; v.sel = 4'hF;
      v.wdata = 32'h1000_0000 + 32'(i); v.exp_hit = 1'b0; v.exp_lat = 5;
      v.exp_data = 32'h0;
      applyStimulus(v);
    end

    do_reset();
    checkOutput("reset data_o", data_o, 32'h0);
    checkOutput("reset hit_o", 32'(hit_o), 32'd0);
    checkOutput("reset ready_o", 32'(ready_o), 32'd0);
    checkOutput("reset busy_o", 32'(busy_o), 32'd0);
`ifdef CACHE_STATS_EN
    checkOutput("reset hit_cnt_o", hit_cnt_o, 32'd0);
    checkOutput("reset miss_cnt_o", miss_cnt_o, 32'd0);
`endif

    //       name                  addr          we    sel    wdata          hit  lat data
    add_vec("rd40_miss",          32'h40,       1'b0, 4'h0, 32'h0,         1'b0, 9, 32'h1000_0010);
    add_vec("rd44_hit",           32'h44,       1'b0, 4'h0, 32'h0,         1'b1, 0, 32'h1000_0011);
    add_vec("wr44_lo16",          32'h44,       1'b1, 4'h3, 32'hAABB_CCDD, 1'b0, 5, 32'h0);
    add_vec("rd44_merged",        32'h44,       1'b0, 4'h0, 32'h0,         1'b1, 0, 32'h1000_CCDD);
    add_vec("rd00_miss",          32'h00,       1'b0, 4'h0, 32'h0,         1'b0, 9, 32'h1000_0000);
    add_vec("rd20_miss",          32'h20,       1'b0, 4'h0, 32'h0,         1'b0, 9, 32'h1000_0008);
    add_vec("rd40_refill",        32'h40,       1'b0, 4'h0, 32'h0,         1'b0, 9, 32'h1000_0010);
    add_vec("rd44_refill_hit",    32'h44,       1'b0, 4'h0, 32'h0,         1'b1, 0, 32'h1000_CCDD);
    add_vec("rd00_evicted",       32'h00,       1'b0, 4'h0, 32'h0,         1'b0, 9, 32'h1000_0000);
    add_vec("rd0C_hit",           32'h0C,       1'b0, 4'h0, 32'h0,         1'b1, 0, 32'h1000_0003);
    add_vec("wr10_sel0",          32'h10,       1'b1, 4'h0, 32'hFFFF_FFFF, 1'b0, 5, 32'h0);
    add_vec("rd10_miss",          32'h10,       1'b0, 4'h0, 32'h0,         1'b0, 9, 32'h1000_0004);
    add_vec("wr14_hi16",          32'h14,       1'b1, 4'hC, 32'h1122_3344, 1'b0, 5, 32'h0);
    add_vec("rd14_hit",           32'h14,       1'b0, 4'h0, 32'h0,         1'b1, 0, 32'h1122_0005);
    add_vec("wr18_full",          32'h18,       1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 5, 32'h0);
    add_vec("rd18_hit",           32'h18,       1'b0, 4'h0, 32'h0,         1'b1, 0, 32'hDEAD_BEEF);
    add_vec("wr10_sel0_resident", 32'h10,       1'b1, 4'h0, 32'hFFFF_FFFF, 1'b0, 5, 32'h0);
    add_vec("rd10_hit",           32'h10,       1'b0, 4'h0, 32'h0,         1'b1, 0, 32'h1000_0004);
    add_vec("rd_alias_high",      32'h1234_5014, 1'b0, 4'h0, 32'h0,        1'b1, 0, 32'h1122_0005);
    add_vec("rd_alias_low",       32'h17,       1'b0, 4'h0, 32'h0,         1'b1, 0, 32'h1122_0005);
    add_vec("wr1C_msb",           32'h1C,       1'b1, 4'h8, 32'h5A00_0000, 1'b0, 5, 32'h0);
    add_vec("rd1E_hit",           32'h1E,       1'b0, 4'h0, 32'h0,         1'b1, 0, 32'h5A00_0007);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
`ifdef CACHE_STATS_EN
      if (i == 1) begin
        checkOutput("stats hit_cnt_o", hit_cnt_o, 32'd1);
        checkOutput("stats miss_cnt_o", miss_cnt_o, 32'd1);
      end
`endif
    end

    // Abort: read miss on 0x80, ce dropped in the second MISS_WAIT cycle.
    ce = 1'b1; we = 1'b0; addr = 32'h80; sel = 4'h0;
    #1;
    checkOutput("abort hit_o", 32'(hit_o), 32'd0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("abort busy_o before drop", 32'(busy_o), 32'd1);
    ce = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort busy_o after drop", 32'(busy_o), 32'd0);
    ready_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (ready_o) ready_seen++;
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("abort no ready_o", 32'(ready_seen), 32'd0);

    v.name = "rd80_after_abort"; v.addr = 32'h80; v.we = 1'b0; v.sel = 4'h0;
    v.wdata = 32'h0; v.exp_hit = 1'b0; v.exp_lat = 9; v.exp_data = 32'h1000_0020;
    applyStimulus(v);
    // The aborted miss invalidated the 0x40 line, so 0x44 misses now.
    v.name = "rd44_after_abort"; v.addr = 32'h44; v.exp_data = 32'h1000_CCDD;
    applyStimulus(v);
    v.name = "rd44_hit_before_rst"; v.exp_hit = 1'b1; v.exp_lat = 0;
    applyStimulus(v);

    // Reset during FILL: miss on 0xA0, rst asserted in the second FILL cycle.
    ce = 1'b1; we = 1'b0; addr = 32'hA0; sel = 4'h0;
    #1;
    checkOutput("rstfill hit_o", 32'(hit_o), 32'd0);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("rstfill busy_o in fill", 32'(busy_o), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstfill data_o", data_o, 32'h0);
    checkOutput("rstfill hit_o after rst", 32'(hit_o), 32'd0);
    checkOutput("rstfill ready_o", 32'(ready_o), 32'd0);
    checkOutput("rstfill busy_o", 32'(busy_o), 32'd0);
    rst = 1'b0;
    ce = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstfill busy_o released", 32'(busy_o), 32'd0);
`ifdef CACHE_STATS_EN
    checkOutput("rstfill hit_cnt_o", hit_cnt_o, 32'd0);
    checkOutput("rstfill miss_cnt_o", miss_cnt_o, 32'd0);
`endif
    v.name = "rd44_after_rst"; v.addr = 32'h44; v.exp_hit = 1'b0; v.exp_lat = 9;
    v.exp_data = 32'h1000_CCDD;
    applyStimulus(v);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
